// File: rtl/ecc_decoder_if.sv
// Request/response bundle between the register front end and the SECDED decoder.
interface ecc_decoder_if #(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [AMBA_WORD-1:0]  CodeWord_Width;
  logic                  En;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            num_of_errors;
  logic                  ready_Decoder;

  modport master (
    output data_in, CodeWord_Width, En,
    input  data_out, num_of_errors, ready_Decoder
  );

  modport slave (
    input  data_in, CodeWord_Width, En,
    output data_out, num_of_errors, ready_Decoder
  );
endinterface

// File: rtl/ecc_decoder.sv
// Extended-Hamming (SECDED) decoder for 8/16/32-bit codewords, IDLE->CALC->FIX->DONE.
// Results land two edges after the accepting edge; ready_Decoder pulses one edge later.
module ecc_decoder #(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  ecc_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] cw_q;
  logic [1:0]            wcode_q;
  logic [4:0]            syn_q;
  logic                  par_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            nerr_q;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] in_mask;
  logic [4:0]            syn_c;
  logic                  par_c;
  logic [DATA_WIDTH-1:0] fixed_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic [1:0]            nerr_c;
  int                    n_bits;

  logic unused_cfg;
  assign unused_cfg = ^bus.CodeWord_Width[AMBA_WORD-1:2];

  always_comb begin
    in_mask = '1;
    case (bus.CodeWord_Width[1:0])
      2'b00:   in_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
      2'b01:   in_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      default: in_mask = '1;
    endcase
  end

  // Captured codeword is already masked to N bits, so the syndrome and parity
  // can run over all positions without knowing the width.
  always_comb begin
    syn_c = '0;
    par_c = ^cw_q;
    for (int p = 1; p < DATA_WIDTH; p++) begin
      if (cw_q[p]) syn_c = syn_c ^ 5'(p);
    end
  end

  always_comb begin
    case (wcode_q)
      2'b00:   n_bits = 8;
      2'b01:   n_bits = 16;
      default: n_bits = 32;
    endcase
  end

  // Odd overall parity means one flipped bit at position S (S=0 is the parity bit itself).
  always_comb begin
    fixed_c = cw_q;
    if (par_q) fixed_c[syn_q] = ~cw_q[syn_q];
  end

  always_comb begin
    int idx;
    data_c = '0;
    idx    = 0;
    for (int p = 3; p < DATA_WIDTH; p++) begin
      if (p < n_bits && (p & (p - 1)) != 0) begin
        data_c[idx] = fixed_c[p];
        idx         = idx + 1;
      end
    end
  end

  always_comb begin
    nerr_c = 2'd0;
    if (par_q)               nerr_c = 2'd1;
    else if (syn_q != 5'd0)  nerr_c = 2'd2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.En) state_nxt = CALC;
      CALC:    state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cw_q    <= '0;
      wcode_q <= '0;
      syn_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      nerr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state == DONE);
      case (state)
        IDLE: if (bus.En) begin
          cw_q    <= bus.data_in & in_mask;
          wcode_q <= bus.CodeWord_Width[1:0];
        end
        CALC: begin
          syn_q <= syn_c;
          par_q <= par_c;
        end
        FIX: begin
          data_q <= data_c;
          nerr_q <= nerr_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out      = data_q;
  assign bus.num_of_errors = nerr_q;
  assign bus.ready_Decoder = ready_q;

endmodule

// File: tb/tb_ecc_decoder.sv
// Directed bench for ecc_decoder: expected results queued at issue, checked at each ready pulse.
module tb_ecc_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  ecc_decoder_if #(.AMBA_WORD(32), .DATA_WIDTH(32)) bus ();

  ecc_decoder #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_pulse"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, bus.data_out, e[33:2]);
      check({tag, "_nerr"}, {30'd0, bus.num_of_errors}, {30'd0, e[1:0]});
    end
  endtask

  // One decode: En for a single accepting edge, then inputs scrambled so a
  // late re-sample of data_in/CodeWord_Width would corrupt the result.
  task automatic decode(input logic [31:0] cw, input logic [1:0] w,
                        input logic [31:0] exp_d, input logic [1:0] exp_n,
                        input bit toggle, input string tag);
    int pulses;
    int first;
    pulses = 0;
    first  = 0;
    @(negedge clk);
    bus.data_in        = cw;
    bus.CodeWord_Width = {30'd0, w} | ($urandom & 32'hFFFF_FFFC);
    bus.En             = 1'b1;
    exp_q.push_back({exp_d, exp_n});
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.data_in        = $urandom;
        bus.CodeWord_Width = $urandom;
      end
      bus.En = toggle && (i == 1 || i == 2);
      if (bus.ready_Decoder) begin
        pulses++;
        if (first == 0) first = i;
        pop_and_check(tag);
      end
    end
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_latency"}, first, 32'd4);
  endtask

  initial begin
    int hs_pulses;
    int hs_pos[$];
    int rst_pulses;

    bus.data_in        = '0;
    bus.CodeWord_Width = '0;
    bus.En             = 1'b0;

    #3;
    check("reset_data", bus.data_out, 32'd0);
    check("reset_nerr", {30'd0, bus.num_of_errors}, 32'd0);
    check("reset_ready", {31'd0, bus.ready_Decoder}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    decode(32'h0000_00AA, 2'b00, 32'h0000_000B, 2'd0, 1'b0, "aa8");
    decode(32'h0000_008A, 2'b00, 32'h0000_000B, 2'd1, 1'b1, "bit5_8");
    decode(32'h0000_00AB, 2'b00, 32'h0000_000B, 2'd1, 1'b0, "bit0_8");
    decode(32'hFFFF_FFAA, 2'b00, 32'h0000_000B, 2'd0, 1'b0, "upper8");
    decode(32'h0000_0082, 2'b00, 32'h0000_0008, 2'd2, 1'b1, "dbl8");
    decode(32'h0000_0000, 2'b01, 32'h0000_0000, 2'd0, 1'b0, "zero16");
    decode(32'h0000_0400, 2'b01, 32'h0000_0000, 2'd1, 1'b0, "bit10_16");
    decode(32'hFFFF_0000, 2'b01, 32'h0000_0000, 2'd0, 1'b0, "upper16");
    decode(32'h0000_0000, 2'b10, 32'h0000_0000, 2'd0, 1'b0, "zero32");
    decode(32'h8000_0000, 2'b10, 32'h0000_0000, 2'd1, 1'b0, "bit31_32");
    decode(32'h8000_0001, 2'b10, 32'h0200_0000, 2'd2, 1'b0, "dbl32");
    decode(32'h8000_0000, 2'b11, 32'h0000_0000, 2'd1, 1'b0, "code3");

    // En held for 10 edges: accepted at k, k+4, k+8 only.
    hs_pulses = 0;
    for (int j = 0; j < 3; j++) exp_q.push_back({32'd0, 2'd0});
    @(negedge clk);
    bus.data_in        = 32'h0000_0000;
    bus.CodeWord_Width = 32'd1;
    bus.En             = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 10) bus.En = 1'b0;
      if (bus.ready_Decoder) begin
        hs_pulses++;
        hs_pos.push_back(i);
        pop_and_check("hold16");
      end
    end
    check("hold16_pulses", hs_pulses, 32'd3);
    if (hs_pos.size() == 3) begin
      check("hold16_pos0", hs_pos[0], 32'd4);
      check("hold16_pos1", hs_pos[1], 32'd8);
      check("hold16_pos2", hs_pos[2], 32'd12);
    end

    decode(32'h0000_00AA, 2'b00, 32'h0000_000B, 2'd0, 1'b0, "pre_rst");

    // Reset lands while the decode sits in FIX.
    @(negedge clk);
    bus.data_in        = 32'h0000_008A;
    bus.CodeWord_Width = 32'd0;
    bus.En             = 1'b1;
    @(negedge clk);
    bus.En = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_data", bus.data_out, 32'd0);
    check("rst_nerr", {30'd0, bus.num_of_errors}, 32'd0);
    check("rst_ready", {31'd0, bus.ready_Decoder}, 32'd0);
    rst_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ready_Decoder) rst_pulses++;
    end
    check("rst_no_pulse", rst_pulses, 32'd0);
    reset = 1'b1;

    decode(32'h0000_00AA, 2'b00, 32'h0000_000B, 2'd0, 1'b0, "post_rst");

    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
